// File: rtl/decrypt_stream.sv
// -----------------------------------------------------------------------------
// decrypt_stream
//
// Streaming decrypt stage with an output FIFO. An encrypted byte and its key
// are captured into a one-entry pipeline stage. On the next edge the byte is
// decrypted and written to the FIFO tail. The FIFO head is presented
// downstream with a valid/ready handshake.
//
// Decryption of byte {hi, lo} with key k:
//   E = {lo[3],lo[0],lo[1],lo[2],lo[1],lo[3],lo[2],lo[0]}
//   X = E ^ k
//   S = (X[7:4] + X[3:0] + (k[0] ? 0 : 1)) mod 16
//   result = {hi ^ S, lo}
//
// Parameters:
//   DEPTH     - output FIFO entries, power of two in 2..16
//
// Ports:
//   clock     - rising-edge clock for all state
//   reset     - synchronous, active-high reset
//   in_valid  - upstream presents an encrypted byte
//   in_data   - encrypted byte {hi nibble, lo nibble}
//   in_key    - key used to encrypt in_data, sampled with it
//   in_ready  - block can accept a byte this cycle
//   out_valid - out_data holds a decrypted byte
//   out_data  - decrypted byte at the FIFO head (8'h00 when empty)
//   out_ready - downstream accepts out_data this cycle
//   level     - FIFO occupancy plus the in-flight stage entry
// -----------------------------------------------------------------------------
module decrypt_stream #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  input  logic [7:0]                 in_key,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [7:0]                 out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  // Pipeline stage
  logic             stage_valid;
  logic [7:0]       stage_data;
  logic [7:0]       stage_key;

  // Output FIFO
  logic [7:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [COUNT_W-1:0] count;

  // Decrypt datapath, evaluated on the stage registers
  logic [3:0]       lo_nib;
  logic [7:0]       expanded;
  logic [7:0]       mixed;
  logic [3:0]       mix_nib;
  logic [7:0]       plain;

  logic             in_fire;
  logic             push;
  logic             pop;

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (here unconditionally), otherwise synthesis infers a latch.
  always_comb begin
    lo_nib   = stage_data[3:0];
    expanded = {lo_nib[3], lo_nib[0], lo_nib[1], lo_nib[2],
                lo_nib[1], lo_nib[3], lo_nib[2], lo_nib[0]};
    mixed    = expanded ^ stage_key;
    // 4-bit sum drops the carry, giving the mod-16 mix.
    mix_nib  = mixed[7:4] + mixed[3:0] + {3'b000, ~stage_key[0]};
    plain    = {stage_data[7:4] ^ mix_nib, lo_nib};
  end

  // The stage entry counts against capacity, so an accepted byte always has a
  // FIFO slot waiting for it one edge later. in_ready depends on registered
  // state only; a pop does not open the input in the same cycle.
  assign level     = count + COUNT_W'(stage_valid);
  assign in_ready  = (level < COUNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : 8'h00;

  assign in_fire   = in_valid && in_ready;
  assign push      = stage_valid;
  assign pop       = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage_valid <= 1'b0;
      stage_data  <= 8'h00;
      stage_key   <= 8'h00;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      stage_valid <= in_fire;
      if (in_fire) begin
        stage_data <= in_data;
        stage_key  <= in_key;
      end

      // Pointers are log2(DEPTH) bits wide, so increment wraps modulo DEPTH.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count <= count + COUNT_W'(1);
        2'b01:   count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the FIFO storage has no reset; out_data is masked while empty, so
  // stale contents are never visible and the array can map to plain RAM.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      fifo_mem[wr_ptr] <= plain;
    end
  end

endmodule

// File: tb/tb_decrypt_stream.sv
// -----------------------------------------------------------------------------
// tb_decrypt_stream
//
// Scoreboard bench for decrypt_stream (DEPTH=4). The driver pushes the
// expected decrypted byte into a queue when a byte is accepted; a monitor on
// the falling edge pops and compares whenever out_valid && out_ready. Inputs
// change 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_decrypt_stream;

  localparam int DEPTH = 4;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] in_key;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];

  decrypt_stream #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_key    (in_key),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Encrypt-stage model used to build round-trip stimulus.
  function automatic logic [7:0] encrypt(input logic [7:0] p, input logic [7:0] k);
    logic [3:0] l;
    logic [7:0] e;
    logic [7:0] x;
    logic [3:0] s;
    l = p[3:0];
    e = {l[3], l[0], l[1], l[2], l[1], l[3], l[2], l[0]};
    x = e ^ k;
    s = x[7:4] + x[3:0] + (k[0] ? 4'd0 : 4'd1);
    return {p[7:4] ^ s, l};
  endfunction

  // Monitor: a pop happens on the next rising edge.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {24'h0, out_data}, 32'hFFFF_FFFF);
      end else begin
        check("out_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // Called just after a rising edge; returns just after the transfer edge.
  task automatic send(input logic [7:0] d, input logic [7:0] k, input logic [7:0] e);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_key   = k;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back(e);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain", {31'h0, out_valid}, 32'd0);
    check("drain_queue", exp_q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_key    = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_out_data",  {24'h0, out_data},  32'h00);
    check("rst_in_ready",  {31'h0, in_ready},  32'd1);
    check("rst_level",     {29'h0, level},     32'd0);

    // Basic decrypt and latency: 76/93 -> 46.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h76;
    in_key    = 8'h93;
    exp_q.push_back(8'h46);
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("lat_valid_edge1", {31'h0, out_valid}, 32'd0);
    check("lat_level_edge1", {29'h0, level},     32'd1);
    @(posedge clock); #1;
    check("lat_valid_edge2", {31'h0, out_valid}, 32'd1);
    check("lat_data_edge2",  {24'h0, out_data},  32'h46);
    wait_empty();

    // Carry wrap: C9/AC -> S=0 -> C9, plus other hand vectors.
    send(8'hC9, 8'hAC, 8'hC9);
    send(8'h81, 8'h42, 8'hC1);
    send(8'hE3, 8'h7E, 8'h73);
    wait_empty();

    // Backpressure: four bytes fill level, fifth held off.
    out_ready = 1'b0;
    send(8'h00, 8'h00, 8'h10);
    send(8'hFF, 8'hFF, 8'hFF);
    send(8'h5A, 8'h01, 8'h2A);
    send(8'h34, 8'h10, 8'h04);
    check("bp_level4",   {29'h0, level},    32'd4);
    check("bp_in_ready", {31'h0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_data  = 8'hE3;
    in_key   = 8'h7E;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("bp_hold_ready", {31'h0, in_ready}, 32'd0);
      check("bp_hold_level", {29'h0, level},    32'd4);
      check("bp_hold_data",  {24'h0, out_data}, 32'h10);
    end
    out_ready = 1'b1;
    check("bp_pop_no_ready", {31'h0, in_ready}, 32'd0);
    send(8'hE3, 8'h7E, 8'h73);
    wait_empty();

    // Full FIFO with simultaneous pop and push.
    out_ready = 1'b0;
    send(8'h5A, 8'h01, 8'h2A);
    send(8'h34, 8'h10, 8'h04);
    send(8'hE3, 8'h7E, 8'h73);
    send(8'h81, 8'h42, 8'hC1);
    @(posedge clock); #1;
    check("full_level", {29'h0, level}, 32'd4);
    out_ready = 1'b1;
    send(8'h76, 8'h93, 8'h46);
    check("full_level_after_xfer", {29'h0, level}, 32'd3);
    @(posedge clock); #1;
    check("full_level_push_pop", {29'h0, level}, 32'd2);
    wait_empty();

    // Reset mid-stream with three bytes buffered; input and pop also active.
    out_ready = 1'b0;
    send(8'h00, 8'h00, 8'h10);
    send(8'hFF, 8'hFF, 8'hFF);
    send(8'h5A, 8'h01, 8'h2A);
    @(posedge clock); #1;
    check("mid_level3", {29'h0, level}, 32'd3);
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h34;
    in_key    = 8'h10;
    out_ready = 1'b1;
    @(posedge clock); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check("mid_out_valid", {31'h0, out_valid}, 32'd0);
    check("mid_level",     {29'h0, level},     32'd0);
    check("mid_in_ready",  {31'h0, in_ready},  32'd1);
    check("mid_out_data",  {24'h0, out_data},  32'h00);
    repeat (5) @(posedge clock);
    #1;
    check("mid_no_stale", {31'h0, out_valid}, 32'd0);
    send(8'h76, 8'h93, 8'h46);
    wait_empty();

    // Round trip through the encrypt model for every byte value.
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] k;
      logic [7:0] p;
      p = 8'(i);
      k = 8'(i * 37 + 11);
      send(encrypt(p, k), k, p);
    end
    wait_empty();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
